alu_iter: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle CPU ALU; sits in the EX stage.
- Single-cycle ops keep the existing 5-bit ALUC encoding and complete in 1 cycle.
- Adds full-width signed/unsigned multiply and divide as iterative radix-2 units producing HI/LO.
- Computes real overflow/carry flags; stage control stalls on `busy`.

---
 rtl/alu_iter.sv | 345 ++++++++++++++++++++++++++++++++++
 tb/tb_alu_iter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// alu_iter: EX-stage ALU with iterative multiply and divide.
//
// Single-cycle ops use the 5-bit ALUC encoding and finish in one cycle.
// MUL/MULU/DIV/DIVU run as radix-2 iterative units: one bit per cycle,
// followed by a sign-fix cycle. The stage stalls while busy is high.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           accept an op (only when busy=0)
//   alu_c           operation code
//   a, b            operands (a[SHW-1:0] is the shift amount for shifts)
//   busy            multi-cycle op in progress, start ignored
//   done            one-cycle pulse, lo/hi/flags valid
//   lo, hi          result / product low / quotient, product high / remainder
//   zero            lo == 0
//   carry           unsigned carry (ADDU/ADD) or borrow (SUBU/SUB/SLTU)
//   sign            SLT/SLTU compare result
//   overflow        signed overflow (ADD/SUB) or DIV MIN/-1
//   div_zero        divide by zero on DIV/DIVU
module alu_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       alu_c,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             carry,
  output logic             sign,
  output logic             overflow,
  output logic             div_zero
);

  localparam logic [4:0] OP_ADDU = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUBU = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b00101;
  localparam logic [4:0] OP_XOR  = 5'b00110;
  localparam logic [4:0] OP_NOR  = 5'b00111;
  localparam logic [4:0] OP_LUI0 = 5'b01000;
  localparam logic [4:0] OP_LUI1 = 5'b01001;
  localparam logic [4:0] OP_SLT  = 5'b01010;
  localparam logic [4:0] OP_SLTU = 5'b01011;
  localparam logic [4:0] OP_SRA  = 5'b01100;
  localparam logic [4:0] OP_SLL0 = 5'b01101;
  localparam logic [4:0] OP_SLL1 = 5'b01110;
  localparam logic [4:0] OP_SRL  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_MULU = 5'b10001;
  localparam logic [4:0] OP_DIV  = 5'b10010;
  localparam logic [4:0] OP_DIVU = 5'b10011;

  // LUI places b[15:0] at the top; for WIDTH<16 it degenerates to b itself.
  localparam int LUI_SH = (WIDTH >= 16) ? (WIDTH - 16) : 0;

  localparam logic [SHW:0]     CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0]     CNT_ONE  = (SHW+1)'(1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // control and output registers (asynchronously reset)
  state_t           state_q, state_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;      // negate product / quotient in FIX
  logic             rneg_q, rneg_d;    // negate remainder in FIX
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             sign_q, sign_d;
  logic             overflow_q, overflow_d;
  logic             div_zero_q, div_zero_d;

  // iterative datapath registers (no reset needed)
  logic [2*WIDTH-1:0] acc_q, acc_d;    // mul: {partial, multiplier}; div: low half = dividend/quotient
  logic [WIDTH-1:0]   rem_q, rem_d;    // partial remainder, always < divisor
  logic [WIDTH-1:0]   opb_q, opb_d;    // multiplicand / divisor magnitude

  // single-cycle datapath
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH:0]          add_w, sub_w;
  logic [SHW-1:0]          sh;
  logic [WIDTH-1:0]        sc_lo;
  logic                    sc_carry, sc_sign, sc_ovf;

  assign a_s   = a;
  assign b_s   = b;
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  assign sh    = a[SHW-1:0];

  always_comb begin
    sc_lo    = '0;
    sc_carry = 1'b0;
    sc_sign  = 1'b0;
    sc_ovf   = 1'b0;
    case (alu_c)
      OP_ADDU: begin
        sc_lo    = add_w[WIDTH-1:0];
        sc_carry = add_w[WIDTH];
      end
      OP_ADD: begin
        sc_lo    = add_w[WIDTH-1:0];
        sc_carry = add_w[WIDTH];
        sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUBU: begin
        sc_lo    = sub_w[WIDTH-1:0];
        sc_carry = sub_w[WIDTH];
      end
      OP_SUB: begin
        sc_lo    = sub_w[WIDTH-1:0];
        sc_carry = sub_w[WIDTH];
        sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  sc_lo = a & b;
      OP_OR:   sc_lo = a | b;
      OP_XOR:  sc_lo = a ^ b;
      OP_NOR:  sc_lo = ~(a | b);
      OP_LUI0, OP_LUI1: sc_lo = b << LUI_SH;
      OP_SLT: begin
        sc_sign = (a_s < b_s);
        sc_lo   = {{(WIDTH-1){1'b0}}, sc_sign};
      end
      OP_SLTU: begin
        // unsigned less-than is exactly the subtract borrow
        sc_sign  = sub_w[WIDTH];
        sc_carry = sub_w[WIDTH];
        sc_lo    = {{(WIDTH-1){1'b0}}, sc_sign};
      end
      OP_SRA:           sc_lo = b_s >>> sh;
      OP_SLL0, OP_SLL1: sc_lo = b << sh;
      OP_SRL:           sc_lo = b >> sh;
      default:          sc_lo = '0;
    endcase
  end

  // operand preparation for the iterative units
  logic             is_mul, is_div, op_signed, div_by_zero, div_ovf;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign is_mul      = (alu_c == OP_MUL) || (alu_c == OP_MULU);
  assign is_div      = (alu_c == OP_DIV) || (alu_c == OP_DIVU);
  assign op_signed   = ~alu_c[0];
  assign abs_a       = (op_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b       = (op_signed && b[WIDTH-1]) ? -b : b;
  assign div_by_zero = is_div && (b == '0);
  assign div_ovf     = (alu_c == OP_DIV) && (a == MIN_VAL) && (b == '1);

  // one radix-2 step of each unit
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_trial;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
  // working remainder is WIDTH+1 bits wide so the trial subtract shows its borrow
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opb_q};

  // sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_q  ? -acc_q : acc_q;
  assign quo_fix  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? -rem_q : rem_q;

  // next-state logic
  logic             upd;
  logic [WIDTH-1:0] res_lo, res_hi;
  logic             res_carry, res_sign, res_ovf, res_dz;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    lo_d       = lo_q;
    hi_d       = hi_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    sign_d     = sign_q;
    overflow_d = overflow_q;
    div_zero_d = div_zero_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    opb_d      = opb_q;
    upd        = 1'b0;
    res_lo     = '0;
    res_hi     = '0;
    res_carry  = 1'b0;
    res_sign   = 1'b0;
    res_ovf    = 1'b0;
    res_dz     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (div_by_zero) begin
            upd    = 1'b1;
            res_lo = '1;
            res_hi = a;
            res_dz = 1'b1;
          end else if (div_ovf) begin
            upd     = 1'b1;
            res_lo  = MIN_VAL;
            res_ovf = 1'b1;
          end else if (is_mul || is_div) begin
            state_d  = RUN;
            busy_d   = 1'b1;
            cnt_d    = CNT_INIT;
            is_div_d = is_div;
            neg_d    = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d   = op_signed && a[WIDTH-1];
            acc_d    = {{WIDTH{1'b0}}, abs_a};
            rem_d    = '0;
            opb_d    = abs_b;
          end else begin
            upd       = 1'b1;
            res_lo    = sc_lo;
            res_carry = sc_carry;
            res_sign  = sc_sign;
            res_ovf   = sc_ovf;
          end
        end
      end
      RUN: begin
        if (is_div_q) begin
          if (!div_trial[WIDTH]) begin
            rem_d = div_trial[WIDTH-1:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = div_shift[WIDTH-1:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = mul_next;
        end
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = FIX;
        end
      end
      FIX: begin
        upd     = 1'b1;
        state_d = IDLE;
        busy_d  = 1'b0;
        if (is_div_q) begin
          res_lo = quo_fix;
          res_hi = rem_fix;
        end else begin
          res_lo = prod_fix[WIDTH-1:0];
          res_hi = prod_fix[2*WIDTH-1:WIDTH];
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (upd) begin
      done_d     = 1'b1;
      lo_d       = res_lo;
      hi_d       = res_hi;
      zero_d     = (res_lo == '0);
      carry_d    = res_carry;
      sign_d     = res_sign;
      overflow_d = res_ovf;
      div_zero_d = res_dz;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      sign_q     <= 1'b0;
      overflow_q <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      sign_q     <= sign_d;
      overflow_q <= overflow_d;
      div_zero_q <= div_zero_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    rem_q <= rem_d;
    opb_q <= opb_d;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign lo       = lo_q;
  assign hi       = hi_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign sign     = sign_q;
  assign overflow = overflow_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed vectors for alu_iter at WIDTH=32 and a seeded
// back-to-back mul/div run at WIDTH=16 against a behavioural model.
module tb_alu_iter;

  localparam logic [4:0] OP_ADDU = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUBU = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00011;
  localparam logic [4:0] OP_NOR  = 5'b00111;
  localparam logic [4:0] OP_LUI  = 5'b01000;
  localparam logic [4:0] OP_SLT  = 5'b01010;
  localparam logic [4:0] OP_SLTU = 5'b01011;
  localparam logic [4:0] OP_SRA  = 5'b01100;
  localparam logic [4:0] OP_SLL  = 5'b01101;
  localparam logic [4:0] OP_SRL  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_MULU = 5'b10001;
  localparam logic [4:0] OP_DIV  = 5'b10010;
  localparam logic [4:0] OP_DIVU = 5'b10011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start32 = 1'b0;
  logic [4:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, zero32, carry32, sign32, ovf32, dz32;
  logic [31:0] lo32, hi32;

  alu_iter #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .alu_c(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .lo(lo32), .hi(hi32), .zero(zero32),
    .carry(carry32), .sign(sign32), .overflow(ovf32), .div_zero(dz32)
  );

  logic        start16 = 1'b0;
  logic [4:0]  op16 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, zero16, carry16, sign16, ovf16, dz16;
  logic [15:0] lo16, hi16;

  alu_iter #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .alu_c(op16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .lo(lo16), .hi(hi16), .zero(zero16),
    .carry(carry16), .sign(sign16), .overflow(ovf16), .div_zero(dz16)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op on the 32-bit DUT, wait for done, check everything.
  // ef = {zero, carry, sign, overflow, div_zero}
  task automatic run32(input string tag, input logic [4:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input int e_lat, input int e_busy,
                       input logic [31:0] elo, input logic [31:0] ehi, input logic [4:0] ef);
    int lat;
    int bc;
    @(negedge clk);
    start32 = 1'b1; op32 = op; a32 = av; b32 = bv;
    @(negedge clk);
    start32 = 1'b0;
    lat = 1;
    bc  = 0;
    while (!done32 && lat < 100) begin
      if (busy32) bc++;
      @(negedge clk);
      lat++;
    end
    check_eq({tag, " latency"}, 64'(lat), 64'(e_lat));
    check_eq({tag, " busy cycles"}, 64'(bc), 64'(e_busy));
    check_eq({tag, " lo"}, 64'(lo32), 64'(elo));
    check_eq({tag, " hi"}, 64'(hi32), 64'(ehi));
    check_eq({tag, " flags"}, 64'({zero32, carry32, sign32, ovf32, dz32}), 64'(ef));
    check_eq({tag, " busy at done"}, 64'(busy32), 64'(0));
    @(negedge clk);
    check_eq({tag, " done width"}, 64'(done32), 64'(0));
  endtask

  function automatic void model16(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] elo, output logic [15:0] ehi,
                                  output logic eo, output logic ed, output int el);
    longint sx, sy, ux, uy, p, q, r;
    sx = $signed(x);
    sy = $signed(y);
    ux = longint'(x);
    uy = longint'(y);
    eo = 1'b0; ed = 1'b0; el = 18;
    elo = '0; ehi = '0;
    p = 0; q = 0; r = 0;
    if (op == OP_MUL || op == OP_MULU) begin
      p = (op == OP_MUL) ? sx * sy : ux * uy;
      elo = p[15:0];
      ehi = p[31:16];
    end else if (y == 16'h0000) begin
      elo = 16'hFFFF; ehi = x; ed = 1'b1; el = 1;
    end else if (op == OP_DIV && x == 16'h8000 && y == 16'hFFFF) begin
      elo = 16'h8000; ehi = 16'h0000; eo = 1'b1; el = 1;
    end else begin
      q = (op == OP_DIV) ? sx / sy : ux / uy;
      r = (op == OP_DIV) ? sx % sy : ux % uy;
      elo = q[15:0];
      ehi = r[15:0];
    end
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        seen_done;
    logic [4:0]  ops[4];
    logic [15:0] e_lo, e_hi;
    logic        e_o, e_d;
    int          e_lat, lat;

    // reset state
    @(posedge clk);
    #1;
    check_eq("reset 32 outs", 64'({busy32, done32, zero32, carry32, sign32, ovf32, dz32}), 64'(0));
    check_eq("reset 32 lo/hi", 64'({lo32, hi32}), 64'(0));
    check_eq("reset 16 outs", 64'({busy16, done16, lo16, hi16, zero16, ovf16, dz16}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // single-cycle ops
    run32("ADD ovf",   OP_ADD,  32'h7FFFFFFF, 32'h1, 1, 0, 32'h80000000, 32'h0, 5'b00010);
    run32("ADDU carry",OP_ADDU, 32'hFFFFFFFF, 32'h1, 1, 0, 32'h0,        32'h0, 5'b11000);
    run32("SLT",       OP_SLT,  32'hFFFFFFFF, 32'h1, 1, 0, 32'h1,        32'h0, 5'b00100);
    run32("SLTU",      OP_SLTU, 32'hFFFFFFFF, 32'h1, 1, 0, 32'h0,        32'h0, 5'b10000);
    run32("SRA",       OP_SRA,  32'h4, 32'h80000000, 1, 0, 32'hF8000000, 32'h0, 5'b00000);
    run32("SUB ovf",   OP_SUB,  32'h80000000, 32'h1, 1, 0, 32'h7FFFFFFF, 32'h0, 5'b00010);
    run32("SUBU borrow",OP_SUBU,32'h1, 32'h2,        1, 0, 32'hFFFFFFFF, 32'h0, 5'b01000);
    run32("LUI",       OP_LUI,  32'h0, 32'h1234ABCD, 1, 0, 32'hABCD0000, 32'h0, 5'b00000);
    run32("NOR",       OP_NOR,  32'h0, 32'h0F0F0F0F, 1, 0, 32'hF0F0F0F0, 32'h0, 5'b00000);
    run32("SLL mask",  OP_SLL,  32'h24, 32'h1,       1, 0, 32'h10,       32'h0, 5'b00000);
    run32("SRL",       OP_SRL,  32'h8, 32'h80000000, 1, 0, 32'h00800000, 32'h0, 5'b00000);
    run32("undef op",  5'b10101, 32'h5, 32'h7,       1, 0, 32'h0,        32'h0, 5'b10000);

    // iterative ops
    run32("MUL",       OP_MUL,  32'hFFFFFFFD, 32'h7, 34, 33, 32'hFFFFFFEB, 32'hFFFFFFFF, 5'b00000);
    run32("MULU",      OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 33, 32'h1, 32'hFFFFFFFE, 5'b00000);
    run32("DIV",       OP_DIV,  32'hFFFFFFF9, 32'h2, 34, 33, 32'hFFFFFFFD, 32'hFFFFFFFF, 5'b00000);
    run32("DIVU",      OP_DIVU, 32'd100, 32'd7,      34, 33, 32'd14, 32'd2, 5'b00000);
    run32("DIVU by 0", OP_DIVU, 32'h12345678, 32'h0, 1, 0, 32'hFFFFFFFF, 32'h12345678, 5'b00001);
    run32("DIV MIN/-1",OP_DIV,  32'h80000000, 32'hFFFFFFFF, 1, 0, 32'h80000000, 32'h0, 5'b00010);
    run32("DIV neg b", OP_DIV,  32'h6, 32'hFFFFFFFD, 34, 33, 32'hFFFFFFFE, 32'h0, 5'b00000);

    // abort a DIV with reset, ignoring a start pulse while busy
    @(negedge clk);
    start32 = 1'b1; op32 = OP_DIV; a32 = 32'd1000; b32 = 32'd3;
    @(negedge clk);
    op32 = OP_ADD; a32 = 32'h1; b32 = 32'h1;
    check_eq("abort busy", 64'(busy32), 64'(1));
    @(negedge clk);
    start32 = 1'b0;
    check_eq("ignored start done", 64'(done32), 64'(0));
    check_eq("ignored start lo", 64'(lo32), 64'(32'hFFFFFFFE));
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen_done = seen_done | done32;
    end
    rst = 1'b1;
    #1;
    check_eq("abort outs", 64'({busy32, done32, zero32, carry32, sign32, ovf32, dz32}), 64'(0));
    check_eq("abort lo/hi", 64'({lo32, hi32}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen_done = seen_done | done32 | busy32;
    end
    check_eq("abort no done", 64'(seen_done), 64'(0));
    run32("ADD after abort", OP_ADD, 32'h2, 32'h3, 1, 0, 32'h5, 32'h0, 5'b00000);

    // WIDTH=16 back-to-back mul/div against the model
    ops[0] = OP_MUL; ops[1] = OP_MULU; ops[2] = OP_DIV; ops[3] = OP_DIVU;
    @(negedge clk);
    op16 = ops[0]; a16 = 16'($urandom); b16 = 16'($urandom);
    model16(op16, a16, b16, e_lo, e_hi, e_o, e_d, e_lat);
    start16 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start16 = 1'b0;
      lat = 1;
      while (!done16 && lat < 60) begin
        @(negedge clk);
        lat++;
      end
      check_eq($sformatf("w16 op%0d latency", i), 64'(lat), 64'(e_lat));
      check_eq($sformatf("w16 op%0d lo", i), 64'(lo16), 64'(e_lo));
      check_eq($sformatf("w16 op%0d hi", i), 64'(hi16), 64'(e_hi));
      check_eq($sformatf("w16 op%0d flags", i), 64'({zero16, ovf16, dz16}),
               64'({(e_lo == 16'h0), e_o, e_d}));
      if (i < 39) begin
        // next op issued on the done cycle
        op16 = ops[(i + 1) % 4];
        a16  = 16'($urandom);
        b16  = 16'($urandom);
        if ((i % 7) == 3) b16 = 16'h0000;
        if ((i % 11) == 5) begin
          op16 = OP_DIV; a16 = 16'h8000; b16 = 16'hFFFF;
        end
        model16(op16, a16, b16, e_lo, e_hi, e_o, e_d, e_lat);
        start16 = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
